// File: rtl/countdown_timer.sv
`default_nettype none
// ============================================================================
//  Module   : countdown_timer
//  Brief    : Programmable down-counter with start/pause/stop control,
//             terminal-count done pulse and optional auto-reload.
//  Revision : 1.0 - initial release
// ============================================================================
module countdown_timer #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             start,
    input  logic             pause,
    input  logic             stop,
    input  logic             auto_reload,
    output logic [WIDTH-1:0] out,
    output logic             busy,
    output logic             done
);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_RUN    = 2'd1;
    localparam logic [1:0] ST_PAUSED = 2'd2;

    localparam logic [WIDTH-1:0] C_ZERO = '0;
    localparam logic [WIDTH-1:0] C_ONE  = WIDTH'(1);

    logic [1:0]       state_q,  state_d;
    logic [WIDTH-1:0] count_q,  count_d;
    logic [WIDTH-1:0] reload_q, reload_d;
    logic             done_q,   done_d;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q  <= ST_IDLE;
            count_q  <= C_ZERO;
            reload_q <= C_ZERO;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            reload_q <= reload_d;
            done_q   <= done_d;
        end
    end

    // Priority load > stop > pause > start; an asserted stop masks start even in IDLE.
    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        reload_d = reload_q;
        done_d   = 1'b0;
        if (load) begin
            count_d  = load_val;
            reload_d = load_val;
            state_d  = ST_IDLE;
        end else if (stop) begin
            state_d = ST_IDLE;
        end else if (pause && (state_q == ST_RUN)) begin
            state_d = ST_PAUSED;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        if (count_q == C_ZERO) begin
                            done_d = 1'b1;
                        end else begin
                            state_d = ST_RUN;
                        end
                    end
                end
                ST_PAUSED: begin
                    if (start) begin
                        state_d = ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (count_q == C_ONE) begin
                        done_d = 1'b1;
                        if (auto_reload && (reload_q != C_ZERO)) begin
                            count_d = reload_q;
                        end else begin
                            count_d = C_ZERO;
                            state_d = ST_IDLE;
                        end
                    end else if (count_q == C_ZERO) begin
                        state_d = ST_IDLE;
                    end else begin
                        count_d = count_q - C_ONE;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    always_comb begin
        out  = count_q;
        busy = (state_q != ST_IDLE);
        done = done_q;
    end

endmodule
`default_nettype wire

// File: tb/tb_countdown_timer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_countdown_timer
//  Brief    : Directed bench for countdown_timer with a cycle-level model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_countdown_timer;

    logic       clk;
    logic       rstn;
    logic       load;
    logic [3:0] load_val;
    logic       start;
    logic       pause;
    logic       stop;
    logic       auto_reload;
    logic [3:0] out;
    logic       busy;
    logic       done;

    int n_checks;
    int n_fail;

    countdown_timer #(.WIDTH(4)) dut (
        .clk        (clk),
        .rstn       (rstn),
        .load       (load),
        .load_val   (load_val),
        .start      (start),
        .pause      (pause),
        .stop       (stop),
        .auto_reload(auto_reload),
        .out        (out),
        .busy       (busy),
        .done       (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0] cnt;
        logic [3:0] rel;
        logic       active;
        logic       frozen;
        logic       pulse;
    } mstate_t;

    mstate_t m;

    function automatic mstate_t model_next(mstate_t s, logic ld, logic [3:0] v,
                                           logic st, logic ps, logic sp, logic ar);
        mstate_t n;
        n       = s;
        n.pulse = 1'b0;
        if (ld) begin
            n.cnt    = v;
            n.rel    = v;
            n.active = 1'b0;
            n.frozen = 1'b0;
        end else if (sp) begin
            n.active = 1'b0;
            n.frozen = 1'b0;
        end else if (ps && s.active && !s.frozen) begin
            n.frozen = 1'b1;
        end else if (s.active && !s.frozen) begin
            if (s.cnt == 4'd1) begin
                n.pulse = 1'b1;
                if (ar && s.rel != 4'd0) begin
                    n.cnt = s.rel;
                end else begin
                    n.cnt    = 4'd0;
                    n.active = 1'b0;
                end
            end else begin
                n.cnt = s.cnt - 4'd1;
            end
        end else if (st && s.frozen) begin
            n.frozen = 1'b0;
        end else if (st && !s.active) begin
            if (s.cnt == 4'd0) n.pulse = 1'b1;
            else               n.active = 1'b1;
        end
        return n;
    endfunction

    always @(posedge clk or negedge rstn) begin
        if (!rstn) m <= '0;
        else       m <= model_next(m, load, load_val, start, pause, stop, auto_reload);
    end

    always @(negedge clk) begin
        n_checks++;
        if (out !== m.cnt || busy !== m.active || done !== m.pulse) begin
            n_fail++;
            $display("FAIL model_cmp t=%0t actual out=%0d busy=%0b done=%0b required out=%0d busy=%0b done=%0b",
                     $time, out, busy, done, m.cnt, m.active, m.pulse);
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s t=%0t actual=%0d required=%0d", name, $time, act, exp);
        end
    endtask

    task automatic chk3(input string name, input int e_out, input int e_busy, input int e_done);
        chk({name, "_out"},  int'(out),  e_out);
        chk({name, "_busy"}, int'(busy), e_busy);
        chk({name, "_done"}, int'(done), e_done);
    endtask

    task automatic step(input logic ld, input logic [3:0] v, input logic st,
                        input logic ps, input logic sp);
        @(negedge clk);
        load     = ld;
        load_val = v;
        start    = st;
        pause    = ps;
        stop     = sp;
        @(posedge clk);
        #1;
        load  = 1'b0;
        start = 1'b0;
        pause = 1'b0;
        stop  = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog t=%0t actual=timeout required=finish", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        n_checks    = 0;
        n_fail      = 0;
        rstn        = 1'b0;
        load        = 1'b0;
        load_val    = 4'd0;
        start       = 1'b0;
        pause       = 1'b0;
        stop        = 1'b0;
        auto_reload = 1'b0;
        repeat (3) @(negedge clk);
        rstn = 1'b1;
        #1;
        chk3("reset", 0, 0, 0);

        // Load and count
        step(1, 4'd5, 0, 0, 0); chk3("ld5", 5, 0, 0);
        step(0, 4'd0, 1, 0, 0); chk3("start5", 5, 1, 0);
        for (int i = 4; i >= 1; i--) begin
            step(0, 4'd0, 0, 0, 0); chk3("cnt5", i, 1, 0);
        end
        step(0, 4'd0, 0, 0, 0); chk3("term5", 0, 0, 1);
        step(0, 4'd0, 0, 0, 0); chk3("post5", 0, 0, 0);

        // Auto-reload with period 3
        auto_reload = 1'b1;
        step(1, 4'd3, 0, 0, 0); chk3("ld3", 3, 0, 0);
        step(0, 4'd0, 1, 0, 0); chk3("ar_start", 3, 1, 0);
        step(0, 4'd0, 0, 0, 0); chk3("ar_a2", 2, 1, 0);
        step(0, 4'd0, 0, 0, 0); chk3("ar_a1", 1, 1, 0);
        step(0, 4'd0, 0, 0, 0); chk3("ar_rel1", 3, 1, 1);
        step(0, 4'd0, 0, 0, 0); chk3("ar_b2", 2, 1, 0);
        step(0, 4'd0, 0, 0, 0); chk3("ar_b1", 1, 1, 0);
        step(0, 4'd0, 0, 0, 0); chk3("ar_rel2", 3, 1, 1);
        step(0, 4'd0, 0, 0, 1); chk3("ar_stop", 3, 0, 0);
        step(0, 4'd0, 0, 0, 0); chk3("ar_hold", 3, 0, 0);
        auto_reload = 1'b0;

        // Pause and resume
        step(1, 4'd8, 0, 0, 0);
        step(0, 4'd0, 1, 0, 0); chk3("p_start", 8, 1, 0);
        step(0, 4'd0, 0, 0, 0);
        step(0, 4'd0, 0, 0, 0); chk3("p_at6", 6, 1, 0);
        step(0, 4'd0, 0, 1, 0); chk3("p_pause", 6, 1, 0);
        step(0, 4'd0, 0, 0, 0); chk3("p_hold1", 6, 1, 0);
        step(0, 4'd0, 0, 0, 0); chk3("p_hold2", 6, 1, 0);
        step(0, 4'd0, 1, 0, 0); chk3("p_resume", 6, 1, 0);
        step(0, 4'd0, 0, 0, 0); chk3("p_5", 5, 1, 0);
        repeat (4) step(0, 4'd0, 0, 0, 0);
        step(0, 4'd0, 0, 0, 0); chk3("p_term", 0, 0, 1);

        // Zero start and full-range count
        step(0, 4'd0, 1, 0, 0); chk3("zero_start", 0, 0, 1);
        step(0, 4'd0, 0, 0, 0); chk3("zero_after", 0, 0, 0);
        step(1, 4'd15, 0, 0, 0);
        step(0, 4'd0, 1, 0, 0); chk3("max_start", 15, 1, 0);
        for (int i = 1; i <= 14; i++) begin
            step(0, 4'd0, 0, 0, 0); chk("max_cnt", int'(out), 15 - i);
        end
        step(0, 4'd0, 0, 0, 0); chk3("max_term", 0, 0, 1);
        step(0, 4'd0, 0, 0, 0); chk3("max_nowrap", 0, 0, 0);

        // Priority
        step(1, 4'd5, 0, 0, 0);
        step(0, 4'd0, 1, 0, 0);
        repeat (3) step(0, 4'd0, 0, 0, 0);
        chk("pri_at2", int'(out), 2);
        step(1, 4'd9, 0, 1, 1); chk3("pri_load", 9, 0, 0);
        step(1, 4'd2, 0, 0, 0);
        step(0, 4'd0, 1, 0, 0);
        step(0, 4'd0, 0, 0, 0); chk3("pri_at1", 1, 1, 0);
        step(1, 4'd7, 0, 0, 0); chk3("pri_term_load", 7, 0, 0);

        // Asynchronous reset mid-run
        step(0, 4'd0, 1, 0, 0);
        repeat (3) step(0, 4'd0, 0, 0, 0);
        chk("rst_pre", int'(out), 4);
        #2;
        rstn = 1'b0;
        #1;
        chk3("async_rst", 0, 0, 0);
        repeat (2) @(negedge clk);
        rstn = 1'b1;
        repeat (3) begin
            step(0, 4'd0, 0, 0, 0); chk3("rst_idle", 0, 0, 0);
        end
        step(1, 4'd3, 0, 0, 0);
        step(0, 4'd0, 1, 0, 0); chk3("rst_restart", 3, 1, 0);
        step(0, 4'd0, 0, 0, 0); chk3("rst_run", 2, 1, 0);

        @(negedge clk);
        #1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/countdown_timer.md
Name: countdown_timer

Overview:
- Programmable down-counter/timer, the decrementing counterpart of the team's free-running up-counter.
- Loaded with a start value, it counts down to zero under start/pause/stop control.
- Emits a one-cycle done pulse at terminal count and can optionally auto-reload for periodic ticks.
- Used as a timeout/interval generator beside the up-counter in the same clock domain.

Parameters:
- WIDTH, 4, bit width of the count, the load value and the reload register.

Ports:
- clk  input  1  single system clock; all state updates on rising edge.
- rstn  input  1  asynchronous, active-low reset.
- load  input  1  capture load_val into the count and the reload register.
- load_val  input  WIDTH  value captured on load.
- start  input  1  begin counting from IDLE, or resume from PAUSED.
- pause  input  1  freeze the count while running.
- stop  input  1  abort to IDLE; the count holds.
- auto_reload  input  1  at terminal count, reload from the reload register and keep running.
- out  output  WIDTH  current count (registered).
- busy  output  1  high in RUN or PAUSED (registered).
- done  output  1  one-cycle terminal-count pulse (registered).

Behaviour:
- Reset (rstn=0, asynchronous, takes effect without a clock edge): out=0, reload register=0, state=IDLE, busy=0, done=0. Reset mid-run aborts immediately.
- States:
  - IDLE: out holds.
  - RUN: out decrements by 1 on each edge.
  - PAUSED: out holds.
- Command priority per edge: load > stop > pause > start. Lower-priority commands in the same cycle are ignored.
- load (any state): out<=load_val, reload register<=load_val, next state IDLE. done is not asserted, even if a terminal count coincides.
- stop in RUN or PAUSED: next state IDLE, out holds, no done.
- pause in RUN: next state PAUSED. pause in IDLE or PAUSED is ignored.
- start:
  - In IDLE with out!=0: next state RUN.
  - In IDLE with out==0: done=1 for one cycle, state stays IDLE, busy stays 0.
  - In PAUSED: next state RUN.
  - In RUN: ignored.
- Latency: start sampled at edge k. out takes values L-1..0 at edges k+1..k+L. out reaches 0 and done=1 together after edge k+L. busy=1 after edges k..k+L-1.
- Terminal, RUN with out==1 at an edge:
  - done<=1 for exactly one cycle.
  - auto_reload=0: out<=0, next state IDLE.
  - auto_reload=1 and reload register!=0: out<=reload register, stay RUN. The period is reload-register cycles; reload=1 gives done every cycle.
  - auto_reload=1 and reload register==0: treated as auto_reload=0.
- No wrap-around: out never decrements below 0. A load of 2^WIDTH-1 (15 at default) counts fully to 0.
- auto_reload is sampled only at the terminal edge. Changing it mid-run has no other effect.
- busy = (state!=IDLE), taken from the state register. done is 0 in every cycle other than those specified above.

Test Plan:
- Load and count: load 5, then start -> out 5,4,3,2,1,0 on successive edges; done high exactly one cycle with out=0; busy high 5 cycles, then 0.
- Auto-reload: auto_reload=1, load 3, start -> out 3,2,1,3,2,1,3...; done pulses every 3 cycles, coincident with each reload; stop -> IDLE, out holds.
- Pause/resume: load 8, start; pause when out=6 -> out stays 6 for 3 cycles with busy=1; start -> 5,4,...,0; done once.
- Zero and maximum: start with out=0 -> single done pulse, busy stays 0; load 15 (WIDTH=4), start -> reaches 0 after 15 edges, never wraps to 15.
- Priority: during RUN at out=2, assert load (val 9) together with stop and pause -> out=9, IDLE, no done. Assert load on the terminal edge -> load wins, no done.
- Async reset: drop rstn mid-run between clock edges (out=4) -> out=0, busy=0, done=0 immediately; the counter stays idle after rstn rises until load/start.
